// File: rtl/checksum_tx.sv
// rtl/checksum_tx.sv - transmit framer emitting a data beat followed by its XOR checksum beat
//
// Purpose: accepts one byte per in_valid/in_ready handshake and drives a two-beat
// frame (data, data ^ KEY) onto the bus with tx_valid/tx_ready flow control.
// Counts frames whose checksum beat has been consumed.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high
//   in_data      in   [7:0] payload byte
//   in_valid     in   payload valid
//   in_ready     out  payload accepted this cycle
//   tx_data      out  [7:0] bus byte (data beat or checksum beat)
//   tx_valid     out  bus byte valid
//   tx_ready     in   bus consumes byte this cycle
//   tx_is_crc    out  current beat is the checksum beat
//   busy         out  frame in progress
//   frame_count  out  [CNT_W-1:0] completed frames, wraps

module checksum_tx #(
    parameter logic [7:0] KEY   = 8'h37,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_is_crc,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_DATA = 2'd1,
        SEND_CRC  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_hold_data;
    logic [7:0]       r_hold_crc;
    logic [CNT_W-1:0] r_frame_count;
    logic             w_load;
    logic             w_count_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_hold_data   <= 8'h00;
            r_hold_crc    <= 8'h00;
            r_frame_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_hold_data <= in_data;
                r_hold_crc  <= in_data ^ KEY;
            end
            if (w_count_inc) begin
                r_frame_count <= r_frame_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_count_inc  = 1'b0;
        in_ready     = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        tx_is_crc    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = ~reset;
                if (in_valid && !reset) begin
                    w_load       = 1'b1;
                    w_next_state = SEND_DATA;
                end
            end
            SEND_DATA: begin
                tx_valid = 1'b1;
                tx_data  = r_hold_data;
                if (tx_ready) begin
                    w_next_state = SEND_CRC;
                end
            end
            SEND_CRC: begin
                tx_valid  = 1'b1;
                tx_data   = r_hold_crc;
                tx_is_crc = 1'b1;
                // The checksum beat leaving frees the holding registers in the
                // same cycle, so a new byte can be taken to overlap frames.
                in_ready  = tx_ready & ~reset;
                if (tx_ready) begin
                    w_count_inc = 1'b1;
                    if (in_valid) begin
                        w_load       = 1'b1;
                        w_next_state = SEND_DATA;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign busy        = (r_state != IDLE);
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_checksum_tx.sv
// tb/tb_checksum_tx.sv - scoreboard bench for checksum_tx

module tb_checksum_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       tx_is_crc;
    logic       busy;
    logic [3:0] frame_count;

    checksum_tx #(.KEY(8'h37), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_is_crc   (tx_is_crc),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = 0;
    int prev_acc = 0;
    logic [3:0] exp_count = 4'd0;
    logic [8:0] sb_q[$];
    int beat_cyc[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented beat against the queue head and pops on transfer.
    always @(negedge clk) begin
        logic [8:0] e;
        if (reset) begin
            sb_q.delete();
            exp_count = 4'd0;
        end else begin
            chk("frame_count", {28'd0, frame_count}, {28'd0, exp_count});
            if (tx_valid) begin
                chk("busy_active", {31'd0, busy}, 32'd1);
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", {31'd0, tx_valid}, 32'd0);
                end else begin
                    e = sb_q[0];
                    chk("tx_data", {24'd0, tx_data}, {24'd0, e[7:0]});
                    chk("tx_is_crc", {31'd0, tx_is_crc}, {31'd0, e[8]});
                    if (tx_ready) begin
                        void'(sb_q.pop_front());
                        beat_cyc.push_back(cyc);
                        if (e[8]) exp_count = exp_count + 4'd1;
                    end
                end
            end else begin
                chk("idle_tx_data", {24'd0, tx_data}, 32'd0);
                chk("idle_tx_is_crc", {31'd0, tx_is_crc}, 32'd0);
                chk("idle_busy", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic keep_valid);
        logic got;
        got = 1'b0;
        in_data = d;
        in_valid = 1'b1;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back({1'b0, d});
                sb_q.push_back({1'b1, d ^ 8'h37});
                prev_acc = last_acc;
                last_acc = cyc;
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!keep_valid) in_valid = 1'b0;
        chk("send_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {28'd0, frame_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single frame: AA -> AA, 9D
        tx_ready = 1'b1;
        send_byte(8'hAA, 1'b0);
        wait_idle();
        chk("single_count", {28'd0, frame_count}, 32'd1);
        chk("single_busy", {31'd0, busy}, 32'd0);

        // Back-to-back: AD, 9A, AF, 98 on consecutive cycles
        do_reset();
        n = beat_cyc.size();
        send_byte(8'hAD, 1'b1);
        send_byte(8'hAF, 1'b0);
        wait_idle();
        chk("b2b_accept_gap", last_acc - prev_acc, 32'd2);
        if (beat_cyc.size() >= n + 4)
            chk("b2b_beat_span", beat_cyc[n+3] - beat_cyc[n], 32'd3);
        else
            chk("b2b_beat_cnt", beat_cyc.size() - n, 32'd4);
        chk("b2b_count", {28'd0, frame_count}, 32'd2);

        // Backpressure: 00 then 37, each stalled three cycles
        do_reset();
        tx_ready = 1'b0;
        send_byte(8'h00, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_data_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_data_hold", {24'd0, tx_data}, 32'h00);
            @(posedge clk);
        end
        #1 tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_crc_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_crc_hold", {24'd0, tx_data}, 32'h37);
            @(posedge clk);
        end
        #1 tx_ready = 1'b1;
        wait_idle();
        chk("bp_count", {28'd0, frame_count}, 32'd1);

        // Reset mid-frame while the FF checksum (C8) is pending
        do_reset();
        tx_ready = 1'b1;
        send_byte(8'hFF, 1'b0);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_in_ready_rst", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        chk("mid_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("mid_tx_data", {24'd0, tx_data}, 32'd0);
        chk("mid_count", {28'd0, frame_count}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        send_byte(8'h12, 1'b0);
        wait_idle();
        chk("mid_after_count", {28'd0, frame_count}, 32'd1);

        // Counter wrap with a 4-bit counter
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            send_byte(8'(i * 7 + 3), 1'b0);
            wait_idle();
            if (i == 15) chk("wrap_15", {28'd0, frame_count}, 32'd15);
            if (i == 16) chk("wrap_16", {28'd0, frame_count}, 32'd0);
            if (i == 17) chk("wrap_17", {28'd0, frame_count}, 32'd1);
        end
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
